// File: rtl/valu_wave_sequencer.sv
// rtl/valu_wave_sequencer.sv - Issues a WAVE-wide vector op to a LANES-wide ALU array in sequential passes
// Optional: VALU_PASS_SKIP_EN skips passes whose EXEC slice is empty instead of issuing them.
module valu_wave_sequencer #(
  parameter int LANES  = 16,
  parameter int WAVE   = 64,
  parameter int DATA_W = 32,
  parameter int CTRL_W = 32,
  parameter int PASSES = WAVE / LANES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_start,
  input  logic [CTRL_W-1:0]       alu_control,
  input  logic [WAVE*DATA_W-1:0]  alu_source1_data,
  input  logic [WAVE*DATA_W-1:0]  alu_source2_data,
  input  logic [WAVE*DATA_W-1:0]  alu_source3_data,
  input  logic [WAVE-1:0]         alu_source_vcc_value,
  input  logic [WAVE-1:0]         alu_source_exec_value,
  output logic                    alu_busy,
  output logic [WAVE*DATA_W-1:0]  alu_vgpr_dest_data,
  output logic [WAVE-1:0]         alu_sgpr_dest_data,
  output logic [WAVE-1:0]         alu_dest_vcc_value,
  output logic [WAVE-1:0]         alu_dest_exec_value,
  output logic                    valu_done,
  output logic                    lane_start,
  output logic [CTRL_W-1:0]       lane_control,
  output logic [LANES*DATA_W-1:0] lane_source1_data,
  output logic [LANES*DATA_W-1:0] lane_source2_data,
  output logic [LANES*DATA_W-1:0] lane_source3_data,
  output logic [LANES-1:0]        lane_source_vcc_value,
  output logic [LANES-1:0]        lane_source_exec_value,
  input  logic [LANES-1:0]        lane_done,
  input  logic [LANES*DATA_W-1:0] lane_vgpr_dest_data,
  input  logic [LANES-1:0]        lane_sgpr_dest_data,
  input  logic [LANES-1:0]        lane_dest_vcc_value
);

  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          pass_q, pass_d;
  logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
  logic [WAVE*DATA_W-1:0] src1_q, src1_d, src2_q, src2_d, src3_q, src3_d;
  logic [WAVE-1:0]        svcc_q, svcc_d, exec_q, exec_d;
  logic [WAVE*DATA_W-1:0] vgpr_q, vgpr_d;
  logic [WAVE-1:0]        sgpr_q, sgpr_d, dvcc_q, dvcc_d;
  logic                   write_slice;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
      ctrl_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      src3_q  <= '0;
      svcc_q  <= '0;
      exec_q  <= '0;
      vgpr_q  <= '0;
      sgpr_q  <= '0;
      dvcc_q  <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      ctrl_q  <= ctrl_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      src3_q  <= src3_d;
      svcc_q  <= svcc_d;
      exec_q  <= exec_d;
      vgpr_q  <= vgpr_d;
      sgpr_q  <= sgpr_d;
      dvcc_q  <= dvcc_d;
    end
  end

  // Present the current pass's slice of the captured wavefront to the lane array.
  always_comb begin
    int base;
    base                   = int'(pass_q) * LANES;
    lane_source1_data      = '0;
    lane_source2_data      = '0;
    lane_source3_data      = '0;
    lane_source_vcc_value  = '0;
    lane_source_exec_value = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_source1_data[l*DATA_W +: DATA_W] = src1_q[(base + l)*DATA_W +: DATA_W];
      lane_source2_data[l*DATA_W +: DATA_W] = src2_q[(base + l)*DATA_W +: DATA_W];
      lane_source3_data[l*DATA_W +: DATA_W] = src3_q[(base + l)*DATA_W +: DATA_W];
      lane_source_vcc_value[l]              = svcc_q[base + l];
      lane_source_exec_value[l]             = exec_q[base + l];
    end
  end

  always_comb begin
    int base;
    base        = int'(pass_q) * LANES;
    state_d     = state_q;
    pass_d      = pass_q;
    ctrl_d      = ctrl_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    src3_d      = src3_q;
    svcc_d      = svcc_q;
    exec_d      = exec_q;
    vgpr_d      = vgpr_q;
    sgpr_d      = sgpr_q;
    dvcc_d      = dvcc_q;
    lane_start  = 1'b0;
    write_slice = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (alu_start && (alu_control != '0)) begin
          ctrl_d  = alu_control;
          src1_d  = alu_source1_data;
          src2_d  = alu_source2_data;
          src3_d  = alu_source3_data;
          svcc_d  = alu_source_vcc_value;
          exec_d  = alu_source_exec_value;
          vgpr_d  = '0;
          sgpr_d  = '0;
          dvcc_d  = '0;
          pass_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef VALU_PASS_SKIP_EN
        if (lane_source_exec_value == '0) begin
          write_slice = 1'b1;
        end else begin
          lane_start = 1'b1;
          state_d    = S_WAIT;
        end
`else
        lane_start = 1'b1;
        state_d    = S_WAIT;
`endif
      end
      S_WAIT: begin
        if (&(lane_done | ~lane_source_exec_value)) begin
          write_slice = 1'b1;
        end
      end
      S_DONE: begin
        pass_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Inactive items get zero VGPR/SGPR and pass their source VCC bit through.
    if (write_slice) begin
      for (int l = 0; l < LANES; l++) begin
        vgpr_d[(base + l)*DATA_W +: DATA_W] = lane_source_exec_value[l] ?
                                              lane_vgpr_dest_data[l*DATA_W +: DATA_W] : '0;
        sgpr_d[base + l] = lane_source_exec_value[l] & lane_sgpr_dest_data[l];
        dvcc_d[base + l] = lane_source_exec_value[l] ? lane_dest_vcc_value[l] :
                                                        lane_source_vcc_value[l];
      end
      if (pass_q == LAST_PASS) begin
        state_d = S_DONE;
      end else begin
        pass_d  = pass_q + PW'(1);
        state_d = S_ISSUE;
      end
    end
  end

  assign alu_busy            = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign valu_done           = (state_q == S_DONE);
  assign lane_control        = ctrl_q;
  assign alu_vgpr_dest_data  = vgpr_q;
  assign alu_sgpr_dest_data  = sgpr_q;
  assign alu_dest_vcc_value  = dvcc_q;
  assign alu_dest_exec_value = exec_q;

endmodule

// File: doc/valu_wave_sequencer.md
Name: valu_wave_sequencer

Overview:
- Parametrised successor to the 16-lane vector ALU wrapper.
- Accepts a full wavefront of WAVE work-items and issues it to a LANES-wide lane-ALU array (simd_alu or simf_alu instances, external to this block) in WAVE/LANES sequential passes.
- Collects each pass's results and assembles wavefront-wide VGPR, SGPR and VCC results.
- Sits between the issue/operand-collect stage and the lane ALU array.

Parameters:
- LANES, 16, number of physical lane ALUs driven per pass.
- WAVE, 64, work-items per wavefront; must be an integer multiple of LANES.
- DATA_W, 32, operand and result width per work-item.
- CTRL_W, 32, width of the ALU control word.
- PASSES, WAVE/LANES, derived; never overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset; asserted when 0.
- alu_start  in  1  start request, one cycle.
- alu_control  in  CTRL_W  opcode/control word; all-zero means no operation.
- alu_source1_data  in  WAVE*DATA_W  operand A; work-item i at bits [i*DATA_W +: DATA_W].
- alu_source2_data  in  WAVE*DATA_W  operand B; same packing.
- alu_source3_data  in  WAVE*DATA_W  operand C; same packing.
- alu_source_vcc_value  in  WAVE  incoming VCC mask.
- alu_source_exec_value  in  WAVE  EXEC mask.
- alu_busy  out  1  high from the cycle after an accepted start until valu_done.
- alu_vgpr_dest_data  out  WAVE*DATA_W  assembled VGPR result.
- alu_sgpr_dest_data  out  WAVE  assembled per-item SGPR result bits.
- alu_dest_vcc_value  out  WAVE  assembled VCC result.
- alu_dest_exec_value  out  WAVE  registered copy of the captured EXEC mask.
- valu_done  out  1  one-cycle completion pulse.
- lane_start  out  1  pass-start pulse to the lane array.
- lane_control  out  CTRL_W  captured control word.
- lane_source1_data  out  LANES*DATA_W  operand A slice for the current pass.
- lane_source2_data  out  LANES*DATA_W  operand B slice for the current pass.
- lane_source3_data  out  LANES*DATA_W  operand C slice for the current pass.
- lane_source_vcc_value  out  LANES  VCC slice for the current pass.
- lane_source_exec_value  out  LANES  EXEC slice for the current pass.
- lane_done  in  LANES  per-lane done from the lane array.
- lane_vgpr_dest_data  in  LANES*DATA_W  per-lane VGPR results.
- lane_sgpr_dest_data  in  LANES  per-lane SGPR result bits.
- lane_dest_vcc_value  in  LANES  per-lane VCC results.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE and the pass counter to 0.
  - All outputs and all captured operand registers go to 0.
  - Reset mid-operation abandons the wavefront; no valu_done is produced.
- Pass slicing: pass p covers work-items p*LANES .. p*LANES+LANES-1. lane_* outputs present that slice of the captured registers, valid whenever state is ISSUE or WAIT.
- IDLE:
  - alu_start==1 with alu_control!=0 captures all sources, control and EXEC; clears all dest registers; sets p=0; moves to ISSUE.
  - Start with alu_control==0 is ignored.
- ISSUE:
  - Computes slice_exec = captured EXEC slice for pass p.
  - slice_exec!=0: lane_start=1 for exactly this cycle, then go to WAIT.
  - slice_exec==0: handled as defined under Optional Feature.
- WAIT: completion when &(lane_done | ~slice_exec) == 1. On completion:
  - Active items: capture lane VGPR/SGPR/VCC results into slice p.
  - Inactive items: VGPR=0, SGPR=0, VCC keeps the source VCC bit.
  - Then go to ISSUE with p+1, or to DONE if p==PASSES-1.
- DONE: valu_done=1 for one cycle, alu_busy drops to 0, return to IDLE.
- Dest outputs hold their values until the next accepted start.
- Latency: start at cycle 0, first lane_start at cycle 1. Each issued pass costs 1 issue cycle plus W wait cycles, where lane_done completes after W>=1 WAIT cycles. valu_done follows one cycle after the final completion.
- alu_start while busy is ignored (no queueing).
- Stale lane_done outside WAIT is ignored.
- lane_start is never asserted outside ISSUE.

Optional Feature:
- Macro: VALU_PASS_SKIP_EN.
- Defined: an ISSUE with slice_exec==0 issues nothing. It writes inactive results for the slice in that same cycle and advances directly to the next pass, or to DONE after the last pass. Cost: 1 cycle per skipped pass.
- Undefined: every pass issues lane_start even with slice_exec==0. Completion is immediate in the first WAIT cycle (mask term all ones), and results follow the inactive-item rules.
- An all-zero EXEC wavefront always terminates with exactly one valu_done pulse.

Test Plan:
- Defaults, EXEC=all ones, lane model done 2 cycles after lane_start -> 4 lane_start pulses; each VGPR result = src1+src2 for its item; valu_done exactly once, at cycle 13.
- EXEC=0x0000_FFFF_0000_FFFF, VCC=all ones, VALU_PASS_SKIP_EN defined -> only passes 0 and 2 issue; items 16-31 and 48-63 have VGPR=0 and VCC=1.
- Same stimulus with the macro undefined -> 4 lane_start pulses; dest values identical to the previous case.
- alu_start with alu_control=0 -> no lane_start, no valu_done, alu_busy stays 0. Second alu_start issued mid-pass -> ignored; only one valu_done.
- rst=0 during pass 2 WAIT -> next cycle all outputs 0, state IDLE; a following start completes normally.
- Lanes with EXEC=0 never raise lane_done, EXEC=0x0000_0000_0000_00FF -> pass 0 completes using lanes 0-7 only; no hang.
